// File: rtl/perf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : perf_pkg
// Description : Shared types and constants for the performance event monitor:
//               FSM state encoding, default sizing and event channel indices.
// Revision    : 1.0 - initial release
// ============================================================================
package perf_pkg;

  // Default sizing used by the monitor when no overrides are given
  localparam int DEF_NUM_EVT = 2;
  localparam int DEF_CNT_W   = 32;

  // Event channel indices
  localparam int EVT_STALL = 0;
  localparam int EVT_FLUSH = 1;

  // Monitor control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : perf_pkg
`default_nettype wire

// File: rtl/perf_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : perf_sat_counter
// Description : CNT_W-bit up-counter that sticks at all-ones. An increment
//               request while already at all-ones raises a sticky overflow
//               flag. Clear has priority over increment.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_d;
  logic             ovf_q;
  logic             at_max;

  assign at_max = &cnt_q;

  // Next count: clear wins, otherwise saturating increment with sticky overflow
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      if (at_max) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Count and overflow registers, synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;
  assign ovf_o     = ovf_q;

endmodule : perf_sat_counter
`default_nettype wire

// File: rtl/perf_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : perf_event_monitor
// Description : Counts per-channel event pulses and elapsed cycles while
//               running, with an optional cycle budget that stops the run,
//               saturating counters with sticky overflow, and a registered
//               read port. Define PERF_SNAPSHOT_EN to add a snapshot bank
//               captured by snap_i and read with rd_snap_i.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_event_monitor
  import perf_pkg::*;
#(
  parameter int NUM_EVT = DEF_NUM_EVT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic                             clr_i,
  input  logic [NUM_EVT-1:0]               evt_i,
  input  logic [CNT_W-1:0]                 cyc_limit_i,
  input  logic                             snap_i,
  input  logic                             rd_snap_i,
  input  logic [$clog2(NUM_EVT+1)-1:0]     rd_sel_i,
  output logic [CNT_W-1:0]                 rd_data_o,
  output logic [CNT_W-1:0]                 cycle_o,
  output logic [NUM_EVT-1:0]               ovf_o,
  output logic                             busy_o,
  output logic                             done_o
);

  // Counter slots 0..NUM_EVT-1 are event channels, slot NUM_EVT is the cycle counter
  localparam int NUM_CNT = NUM_EVT + 1;
  localparam int CYC_IDX = NUM_EVT;

  state_e           state_d;
  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic             count_en;
  logic             limit_hit;
  logic [NUM_EVT:0] inc_w;
  logic [NUM_EVT:0] ovf_w;
  logic [CNT_W-1:0] live_cnt [NUM_CNT];
  logic [CNT_W-1:0] live_nxt [NUM_CNT];
  logic [CNT_W-1:0] rd_bank  [NUM_CNT];
  logic [CNT_W-1:0] rd_data_d;
  logic [CNT_W-1:0] rd_data_q;
  logic             cyc_ovf_unused;

  // Counting only happens in RUN with start held; clear suppresses it
  assign count_en = (state_q == ST_RUN) && start_i && !clr_i;
  assign inc_w    = {count_en, evt_i & {NUM_EVT{count_en}}};

  // Stop only on an exact match of a count that actually advanced this cycle,
  // so a budget at or below a saturated count never fires
  assign limit_hit = count_en
                  && (cyc_limit_i != '0)
                  && (live_nxt[CYC_IDX] != live_cnt[CYC_IDX])
                  && (live_nxt[CYC_IDX] == cyc_limit_i);

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    perf_sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (clr_i),
      .inc_i     (inc_w[k]),
      .cnt_o     (live_cnt[k]),
      .cnt_nxt_o (live_nxt[k]),
      .ovf_o     (ovf_w[k])
    );
  end

  assign ovf_o          = ovf_w[NUM_EVT-1:0];
  // Cycle counter saturates silently
  assign cyc_ovf_unused = ovf_w[CYC_IDX];
  assign cycle_o        = live_cnt[CYC_IDX];

  // Next-state logic; clear forces IDLE ahead of start and limit
  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) state_d = ST_RUN;
        ST_RUN: begin
          if (!start_i)       state_d = ST_IDLE;
          else if (limit_hit) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register with status outputs registered alongside it
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] snap_d [NUM_CNT];
  logic [CNT_W-1:0] snap_q [NUM_CNT];

  // Capture this cycle's updated values, or the pre-clear values when clearing
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      snap_d[i] = snap_q[i];
      if (snap_i) snap_d[i] = clr_i ? live_cnt[i] : live_nxt[i];
    end
  end

  // Snapshot bank registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NUM_CNT; i++) snap_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) snap_q[i] <= snap_d[i];
    end
  end

  // Read bank select between snapshot and live counters
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      rd_bank[i] = rd_snap_i ? snap_q[i] : live_cnt[i];
    end
  end
`else
  logic snap_unused;
  assign snap_unused = snap_i | rd_snap_i;

  // Without a snapshot bank every read comes from the live counters
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      rd_bank[i] = live_cnt[i];
    end
  end
`endif

  // Read mux; indices past the cycle counter return zero
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (int'(rd_sel_i) == i) rd_data_d = rd_bank[i];
    end
  end

  // Registered read data reflects counter values before this edge's update
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule : perf_event_monitor
`default_nettype wire

// File: tb/tb_perf_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_perf_event_monitor
// Description : Directed self-checking bench for perf_event_monitor. A
//               default-sized instance covers limit stop, pause, clear,
//               snapshot collision and reset; a 4-bit instance covers
//               saturation and overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_event_monitor;
  import perf_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default-sized instance
  logic        rst, start, clr, snap, rd_snap;
  logic [1:0]  evt, rd_sel, ovf;
  logic [31:0] limit, rd_data, cycle;
  logic        busy, done;

  // 4-bit instance for saturation
  logic        s_rst, s_start, s_clr, s_snap, s_rd_snap;
  logic [1:0]  s_evt, s_rd_sel, s_ovf;
  logic [3:0]  s_limit, s_rd_data, s_cycle;
  logic        s_busy, s_done;

  int checks   = 0;
  int failures = 0;

  perf_event_monitor u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clr_i(clr), .evt_i(evt),
    .cyc_limit_i(limit), .snap_i(snap), .rd_snap_i(rd_snap), .rd_sel_i(rd_sel),
    .rd_data_o(rd_data), .cycle_o(cycle), .ovf_o(ovf), .busy_o(busy), .done_o(done)
  );

  perf_event_monitor #(.NUM_EVT(2), .CNT_W(4)) u_sat (
    .clk_i(clk), .rst_i(s_rst), .start_i(s_start), .clr_i(s_clr), .evt_i(s_evt),
    .cyc_limit_i(s_limit), .snap_i(s_snap), .rd_snap_i(s_rd_snap), .rd_sel_i(s_rd_sel),
    .rd_data_o(s_rd_data), .cycle_o(s_cycle), .ovf_o(s_ovf), .busy_o(s_busy), .done_o(s_done)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_snap;

  initial begin
    rst = 1'b0; start = 1'b0; clr = 1'b0; snap = 1'b0; rd_snap = 1'b0;
    evt = 2'b00; rd_sel = 2'd0; limit = 32'd0;
    s_rst = 1'b0; s_start = 1'b0; s_clr = 1'b0; s_snap = 1'b0; s_rd_snap = 1'b0;
    s_evt = 2'b00; s_rd_sel = 2'd0; s_limit = 4'd0;
`ifdef PERF_SNAPSHOT_EN
    exp_snap = 32'd7;
`else
    exp_snap = 32'd0;
`endif

    // Reset state
    step(2);
    check("rst_rd_data", rd_data, 0);
    check("rst_cycle",   cycle,   0);
    check("rst_ovf",     ovf,     0);
    check("rst_busy",    busy,    0);
    check("rst_done",    done,    0);

    // Limit stop at 30 cycles; stall 4 events, flush 2 events
    rst = 1'b1; limit = 32'd30; start = 1'b1;
    step(1);
    check("run_enter_busy",  busy,  1);
    check("run_enter_cycle", cycle, 0);
    evt = 2'b11; step(2);
    evt = 2'b01; step(2);
    evt = 2'b00;
    check("lim_cycle4", cycle, 4);
    step(25);
    check("lim_cycle29", cycle, 29);
    check("lim_done29",  done,  0);
    step(1);
    check("lim_cycle30", cycle, 30);
    check("lim_done30",  done,  1);
    check("lim_busy30",  busy,  0);
    evt = 2'b11; step(2); evt = 2'b00;
    check("done_hold_cycle", cycle, 30);
    rd_sel = EVT_STALL[1:0]; step(1);
    check("lim_rd_stall", rd_data, 4);
    rd_sel = EVT_FLUSH[1:0]; step(1);
    check("lim_rd_flush", rd_data, 2);
    rd_sel = 2'd2; step(1);
    check("lim_rd_cycle", rd_data, 30);
    rd_sel = 2'd3; step(1);
    check("lim_rd_oor", rd_data, 0);

    // Clear out of DONE
    clr = 1'b1; step(1); clr = 1'b0;
    check("clr_done",  done,  0);
    check("clr_cycle", cycle, 0);

    // Pause mid-run with events present
    limit = 32'd0; start = 1'b1; step(1);
    evt = 2'b01; step(3);
    check("pre_pause_cycle", cycle, 3);
    start = 1'b0; evt = 2'b11; step(5);
    check("pause_cycle", cycle, 3);
    check("pause_busy",  busy,  0);
    rd_sel = 2'd0; step(1);
    check("pause_rd_stall", rd_data, 3);
    rd_sel = 2'd1; step(1);
    check("pause_rd_flush", rd_data, 0);
    start = 1'b1; evt = 2'b01; step(2);
    check("resume_cycle", cycle, 4);
    evt = 2'b00; step(1);
    check("resume_cycle5", cycle, 5);

    // Budget below current count never fires; exact later match does
    limit = 32'd3; rd_sel = 2'd0; step(1);
    check("below_rd_stall", rd_data, 4);
    check("below_done6",    done,    0);
    step(1);
    check("below_done7", done, 0);
    check("below_busy7", busy, 1);
    limit = 32'd9; step(1);
    check("match_done8", done, 0);
    step(1);
    check("match_cycle9", cycle, 9);
    check("match_done9",  done,  1);

    // Snapshot and clear in the same cycle with live stall = 7
    clr = 1'b1; start = 1'b0; limit = 32'd0; step(1); clr = 1'b0;
    start = 1'b1; step(1);
    evt = 2'b01; step(7); evt = 2'b00;
    check("coll_cycle7", cycle, 7);
    snap = 1'b1; clr = 1'b1; start = 1'b0; step(1);
    snap = 1'b0; clr = 1'b0;
    check("coll_busy",  busy,  0);
    check("coll_cycle", cycle, 0);
    rd_snap = 1'b1; rd_sel = 2'd0; step(1);
    check("coll_rd_snap", rd_data, exp_snap);
    rd_snap = 1'b0; step(1);
    check("coll_rd_live", rd_data, 0);
    check("coll_done",    done,    0);

    // Reset mid-run at cycle count 12
    start = 1'b1; step(1);
    evt = 2'b11; step(12);
    check("mid_cycle12", cycle, 12);
    rst = 1'b0; step(1);
    check("mid_rst_cycle", cycle,   0);
    check("mid_rst_ovf",   ovf,     0);
    check("mid_rst_busy",  busy,    0);
    check("mid_rst_done",  done,    0);
    check("mid_rst_rd",    rd_data, 0);
    rst = 1'b1; start = 1'b0; evt = 2'b00; rd_sel = 2'd3; step(1);
    check("mid_rd_oor",   rd_data, 0);
    check("mid_idle",     busy,    0);
    check("mid_no_count", cycle,   0);
    rd_snap = 1'b1; rd_sel = 2'd0; step(1);
    check("mid_rd_snap_cleared", rd_data, 0);
    rd_snap = 1'b0; rd_sel = 2'd0; step(1);
    check("mid_rd_stall_cleared", rd_data, 0);
    start = 1'b1; step(1);
    check("mid_resume_busy",  busy,  1);
    check("mid_resume_cycle", cycle, 0);
    step(1);
    check("mid_resume_cycle1", cycle, 1);

    // Saturation with 4-bit counters
    s_rst = 1'b1; s_start = 1'b1; step(1);
    s_evt = 2'b01; step(15);
    check("sat_cycle15",  s_cycle, 15);
    check("sat_ovf_at15", s_ovf,   0);
    step(5);
    check("sat_cycle_hold", s_cycle, 15);
    check("sat_ovf",        s_ovf,   1);
    check("sat_done",       s_done,  0);
    s_evt = 2'b00; s_rd_sel = 2'd0; step(1);
    check("sat_rd_stall", s_rd_data, 15);
    s_rd_sel = 2'd1; step(1);
    check("sat_rd_flush", s_rd_data, 0);
    s_clr = 1'b1; step(1); s_clr = 1'b0;
    check("sat_clr_ovf",   s_ovf,   0);
    check("sat_clr_cycle", s_cycle, 0);
    check("sat_clr_busy",  s_busy,  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_perf_event_monitor
`default_nettype wire

// File: doc/perf_event_monitor.md
PERF_EVENT_MONITOR -- requirements
Module: perf_event_monitor

Interface
REQ-001 Parameter NUM_EVT, default 2, number of event channels (channel 0 = stall, channel 1 = flush).
REQ-002 Parameter CNT_W, default 32, width of every event counter and of the cycle counter.
REQ-003 Port clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_i  in  1  synchronous, active-low reset.
REQ-005 Port start_i  in  1  run enable: high counts, low pauses.
REQ-006 Port clr_i  in  1  synchronous clear of all counters and flags.
REQ-007 Port evt_i  in  NUM_EVT  per-channel event pulse, one count per high cycle.
REQ-008 Port cyc_limit_i  in  CNT_W  cycle budget; 0 = unlimited.
REQ-009 Port snap_i  in  1  snapshot request.
REQ-010 Port rd_snap_i  in  1  read source: 1 = snapshot bank, 0 = live bank.
REQ-011 Port rd_sel_i  in  $clog2(NUM_EVT+1)  read index; NUM_EVT selects the cycle counter.
REQ-012 Port rd_data_o  out  CNT_W  registered read data.
REQ-013 Port cycle_o  out  CNT_W  live cycle count.
REQ-014 Port ovf_o  out  NUM_EVT  sticky per-channel saturation flag.
REQ-015 Port busy_o  out  1  high in RUN.
REQ-016 Port done_o  out  1  high in DONE.

Function
REQ-017 FSM states SHALL be IDLE, RUN and DONE.
- IDLE->RUN when start_i=1.
- RUN->IDLE when start_i=0 (pause; counters hold).
- RUN->DONE on the cycle the post-increment cycle count equals a non-zero cyc_limit_i.
- DONE->IDLE only on clr_i.
REQ-018 In RUN, the cycle counter SHALL increment by 1 every cycle, including the cycle that enters DONE.
REQ-019 In RUN, counter k SHALL increment when evt_i[k]=1; events in IDLE or DONE SHALL be ignored.
REQ-020 A counter at all-ones SHALL hold, and when a further event arrives ovf_o[k] SHALL set and stay set until clr_i or reset.
REQ-021 The cycle counter SHALL saturate at all-ones with no flag.
REQ-022 clr_i SHALL zero all live counters and ovf_o and force IDLE, with priority over start_i, evt_i and the limit check in the same cycle.
REQ-023 rd_data_o SHALL present the selected counter one cycle after rd_sel_i/rd_snap_i are sampled.
- Out-of-range rd_sel_i returns 0.
- The value returned is the counter as it stood before that edge's update.
REQ-024 cyc_limit_i SHALL be sampled every cycle.
- A limit at or below the current count while in RUN SHALL NOT trigger DONE.
- Only an exact match triggers DONE.

Reset
REQ-025 While rst_i=0 at a rising edge, the block SHALL:
- enter IDLE;
- zero all live and snapshot counters, cycle_o, ovf_o and rd_data_o;
- drive busy_o and done_o to 0.
REQ-026 Reset mid-RUN SHALL discard all counts, and counting SHALL resume only after rst_i=1 and start_i=1.

Configuration
REQ-027 With PERF_SNAPSHOT_EN defined:
- snap_i=1 SHALL copy every live counter's post-update value for that cycle into the snapshot bank.
- If clr_i is asserted in the same cycle, the copy SHALL take the pre-clear values.
- rd_snap_i=1 SHALL read the snapshot bank.
REQ-028 Without PERF_SNAPSHOT_EN:
- No snapshot storage SHALL exist.
- snap_i and rd_snap_i SHALL be ignored.
- All reads SHALL return the live bank.

Structure
REQ-029 Package perf_pkg SHALL hold the FSM state enum, default NUM_EVT/CNT_W constants and channel index constants EVT_STALL=0 and EVT_FLUSH=1.
REQ-030 One sub-module, perf_sat_counter (CNT_W saturating counter with inc, clr and ovf), SHALL be instantiated NUM_EVT+1 times.

Verification
REQ-031 Limit stop: start_i=1, cyc_limit_i=30, evt_i[0] high 4 cycles, evt_i[1] high 2 cycles -> done_o after exactly 30 RUN cycles, cycle_o=30, reads give 4 and 2.
REQ-032 Pause: start_i low for 5 cycles mid-run with evt_i high -> counters and cycle_o unchanged across the pause, then resume.
REQ-033 Saturation: CNT_W=4, evt_i[0] high 20 cycles -> counter 15, ovf_o[0]=1, ovf_o[1]=0.
REQ-034 clr/snap collision: snap_i and clr_i together with live stall=7 -> snapshot read (rd_snap_i=1) returns 7, live read returns 0, state IDLE (PERF_SNAPSHOT_EN build); same stimulus without the macro -> both reads 0.
REQ-035 Reset mid-run: rst_i=0 for 1 cycle at count 12 -> all outputs 0, IDLE; rd_sel_i=NUM_EVT+1 -> rd_data_o=0.
